// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared widths and types for the hazard detection / forwarding unit.
//   AW    : register address width
//   DW    : operand / result data width
//   DEPTH : number of in-flight stages after decode (E, M, W)
//   TW    : width of a latency ("tnew"/"tuse") field, wide enough for 0..DEPTH
//   entry_t : one in-flight scoreboard entry {valid, addr, tnew}
// -----------------------------------------------------------------------------
package hazard_pkg;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 3;
  localparam int TW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [TW-1:0] tnew;
  } entry_t;

endpackage : hazard_pkg

// File: rtl/fwd_port_sel.sv
// -----------------------------------------------------------------------------
// fwd_port_sel
// Per-read-port forwarding selector. Finds the youngest valid in-flight entry
// whose destination matches the read address, then either forwards that
// stage's result (result already produced, tnew == 0) or falls back to the
// register file. Raises stall_req when the producer's result will not be ready
// by the time the consumer needs it (tnew > tuse). Address 0 never matches.
//
// Ports
//   ent_valid  in  DEPTH      valid bit per stage (bit k = stage k, 0 youngest)
//   ent_addr   in  DEPTH*AW   destination address per stage
//   ent_tnew   in  DEPTH*TW   remaining result latency per stage
//   stg_data   in  DEPTH*DW   result data per stage
//   rd_addr    in  AW         source register address of this port
//   rd_tuse    in  TW         cycles until this port's operand is consumed
//   rf_data    in  DW         register-file read data for this port
//   rd_data    out DW         selected operand
//   stall_req  out 1          this port needs decode to be held
// -----------------------------------------------------------------------------
module fwd_port_sel #(
  parameter int DEPTH = hazard_pkg::DEPTH,
  parameter int DW    = hazard_pkg::DW,
  parameter int AW    = hazard_pkg::AW,
  parameter int TW    = $clog2(DEPTH + 1)
) (
  input  logic [DEPTH-1:0]    ent_valid,
  input  logic [DEPTH*AW-1:0] ent_addr,
  input  logic [DEPTH*TW-1:0] ent_tnew,
  input  logic [DEPTH*DW-1:0] stg_data,
  input  logic [AW-1:0]       rd_addr,
  input  logic [TW-1:0]       rd_tuse,
  input  logic [DW-1:0]       rf_data,
  output logic [DW-1:0]       rd_data,
  output logic                stall_req
);

  logic          hit;
  logic [TW-1:0] hit_tnew;
  logic [DW-1:0] hit_data;

  // Scan oldest to youngest so a younger match overwrites an older one.
  always_comb begin
    hit      = 1'b0;
    hit_tnew = '0;
    hit_data = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (ent_valid[k] && (ent_addr[k*AW +: AW] == rd_addr)) begin
        hit      = 1'b1;
        hit_tnew = ent_tnew[k*TW +: TW];
        hit_data = stg_data[k*DW +: DW];
      end
    end
    // The zero register is hard-wired; it never has a producer.
    if (rd_addr == '0) begin
      hit = 1'b0;
    end
  end

  assign rd_data   = (hit && (hit_tnew == '0)) ? hit_data : rf_data;
  assign stall_req = hit && (hit_tnew > rd_tuse);

endmodule : fwd_port_sel

// File: rtl/hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// hazard_fwd_unit
// Decode-stage hazard detection and operand forwarding. Tracks DEPTH in-flight
// destinations {valid, addr, tnew} in a shift register (stage 0 youngest),
// forwards results to NUM_RD read ports and stalls decode on load-use hazards.
//
// Optional feature: define HAZARD_STALL_CNT_EN to add a free-running 32-bit
// stall_cnt output counting cycles with stall=1 (wraps at 2^32).
//
// Ports
//   clk        in  1           clock
//   rst_n      in  1           asynchronous active-low reset
//   iss_valid  in  1           decoded instruction writes a register
//   iss_addr   in  AW          its destination register
//   iss_tnew   in  TW          its result latency in cycles
//   flush      in  1           drop every in-flight entry at the next edge
//   stg_data   in  DEPTH*DW    result data per stage (slice k = stage k)
//   rd_addr    in  NUM_RD*AW   source address per read port
//   rd_tuse    in  NUM_RD*TW   consume time per read port
//   rf_data    in  NUM_RD*DW   register-file data per read port
//   rd_data    out NUM_RD*DW   forwarded or register-file operand per port
//   stall      out 1           freeze fetch/decode
//   stall_cnt  out 32          stall cycle counter (HAZARD_STALL_CNT_EN only)
// -----------------------------------------------------------------------------
module hazard_fwd_unit #(
  parameter int NUM_RD   = 2,
  parameter int DEPTH    = hazard_pkg::DEPTH,
  parameter int DW       = hazard_pkg::DW,
  parameter int AW       = hazard_pkg::AW,
  localparam int TW      = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_addr,
  input  logic [TW-1:0]        iss_tnew,
  input  logic                 flush,
  input  logic [DEPTH*DW-1:0]  stg_data,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  input  logic [NUM_RD*TW-1:0] rd_tuse,
  input  logic [NUM_RD*DW-1:0] rf_data,
  output logic [NUM_RD*DW-1:0] rd_data,
  output logic                 stall
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cnt
`endif
);

  localparam logic [TW-1:0] TNEW_MAX = TW'(DEPTH);

  logic [DEPTH-1:0] valid_reg;
  logic [AW-1:0]    addr_reg [DEPTH];
  logic [TW-1:0]    tnew_reg [DEPTH];

  logic [DEPTH*AW-1:0] addr_flat;
  logic [DEPTH*TW-1:0] tnew_flat;
  logic [NUM_RD-1:0]   stall_req;
  logic [TW-1:0]       iss_tnew_clip;

  // A latency longer than the pipe is indistinguishable from "ready at W".
  assign iss_tnew_clip = (iss_tnew > TNEW_MAX) ? TNEW_MAX : iss_tnew;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign addr_flat[gi*AW +: AW] = addr_reg[gi];
      assign tnew_flat[gi*TW +: TW] = tnew_reg[gi];
    end
  endgenerate

  // Scoreboard shift register. Flush wins over stall and issue; a stalled
  // decode inserts a bubble while older entries keep draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        addr_reg[k] <= '0;
        tnew_reg[k] <= '0;
      end
    end else if (flush) begin
      valid_reg <= '0;
    end else begin
      valid_reg[0] <= !stall && iss_valid && (iss_addr != '0);
      addr_reg[0]  <= stall ? '0 : iss_addr;
      tnew_reg[0]  <= stall ? '0 : iss_tnew_clip;
      for (int k = 1; k < DEPTH; k++) begin
        valid_reg[k] <= valid_reg[k-1];
        addr_reg[k]  <= addr_reg[k-1];
        tnew_reg[k]  <= (tnew_reg[k-1] == '0) ? '0 : tnew_reg[k-1] - TW'(1);
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_port
      fwd_port_sel #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW),
        .TW    (TW)
      ) u_sel (
        .ent_valid (valid_reg),
        .ent_addr  (addr_flat),
        .ent_tnew  (tnew_flat),
        .stg_data  (stg_data),
        .rd_addr   (rd_addr[gi*AW +: AW]),
        .rd_tuse   (rd_tuse[gi*TW +: TW]),
        .rf_data   (rf_data[gi*DW +: DW]),
        .rd_data   (rd_data[gi*DW +: DW]),
        .stall_req (stall_req[gi])
      );
    end
  endgenerate

  assign stall = |stall_req;

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule : hazard_fwd_unit

// File: tb/tb_hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_fwd_unit
// Scoreboard bench for hazard_fwd_unit (DEPTH=3, NUM_RD=2). The driver applies
// one cycle of stimulus, computes the expected outputs from a reference model
// that tracks issued instructions by issue time (not a shift register), and
// queues them; a monitor pops and compares against the DUT each cycle.
// Define HAZARD_STALL_CNT_EN to also check stall_cnt.
// -----------------------------------------------------------------------------
module tb_hazard_fwd_unit;

  localparam int DEPTH = 3;
  localparam int NRD   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic [1:0]  iss_tnew;
  logic        flush;
  logic [95:0] stg_data;
  logic [9:0]  rd_addr;
  logic [3:0]  rd_tuse;
  logic [63:0] rf_data;
  logic [63:0] rd_data;
  logic        stall;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  hazard_fwd_unit #(.NUM_RD(NRD), .DEPTH(DEPTH), .DW(32), .AW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_tnew  (iss_tnew),
    .flush     (flush),
    .stg_data  (stg_data),
    .rd_addr   (rd_addr),
    .rd_tuse   (rd_tuse),
    .rf_data   (rf_data),
    .rd_data   (rd_data),
    .stall     (stall)
`ifdef HAZARD_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // ---------------- reference model ----------------
  typedef struct { int addr; int lat; int load; } flight_t;
  typedef struct { logic st; logic [31:0] d0; logic [31:0] d1; logic [31:0] cnt; } exp_t;

  flight_t     fl[$];
  exp_t        exp_q[$];
  int          cyc = 0;
  logic [31:0] m_cnt = '0;
  int          n_test = 0;
  int          n_fail = 0;
  int          n_txn = 0;
  int          dut_stall_seen = 0;
  event        sample_ev;

  // Operand for one port: youngest matching producer, result age derived from
  // how many cycles have passed since it was issued.
  function automatic void model_port(input int ra, input int tu, input logic [95:0] stg,
                                     input logic [31:0] rf, output logic [31:0] d,
                                     output logic st);
    int best;
    int stage;
    int rem;
    best = -1;
    d    = rf;
    st   = 1'b0;
    if (ra == 0) return;
    foreach (fl[j]) begin
      if (fl[j].addr == ra && (best < 0 || fl[j].load > fl[best].load)) best = j;
    end
    if (best >= 0) begin
      stage = cyc - fl[best].load;
      rem   = fl[best].lat - stage;
      if (rem < 0) rem = 0;
      if (rem > tu) st = 1'b1;
      if (rem == 0) d = stg[stage*32 +: 32];
    end
  endfunction

  function automatic logic [95:0] r96();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [63:0] r64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_test++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // One clock of stimulus plus the model update at the following edge.
  task automatic step(input logic iv, input logic [4:0] ia, input logic [1:0] it,
                      input logic fl_in, input logic [4:0] ra0, input logic [1:0] tu0,
                      input logic [4:0] ra1, input logic [1:0] tu1,
                      input logic [95:0] stg, input logic [63:0] rf);
    exp_t        e;
    logic [31:0] d0, d1;
    logic        s0, s1;
    int          lat;
    @(negedge clk);
    rst_n     = 1'b1;
    iss_valid = iv;
    iss_addr  = ia;
    iss_tnew  = it;
    flush     = fl_in;
    rd_addr   = {ra1, ra0};
    rd_tuse   = {tu1, tu0};
    stg_data  = stg;
    rf_data   = rf;
    #1;
    model_port(int'(ra0), int'(tu0), stg, rf[31:0], d0, s0);
    model_port(int'(ra1), int'(tu1), stg, rf[63:32], d1, s1);
    e.st  = s0 | s1;
    e.d0  = d0;
    e.d1  = d1;
    e.cnt = m_cnt;
    exp_q.push_back(e);
    -> sample_ev;
    @(posedge clk);
    if (e.st) m_cnt = m_cnt + 32'd1;
    cyc++;
    if (fl_in) begin
      fl.delete();
    end else begin
      for (int j = fl.size() - 1; j >= 0; j--) begin
        if (cyc - fl[j].load >= DEPTH) fl.delete(j);
      end
      if (!e.st && iv && ia != 5'd0) begin
        lat = (int'(it) > DEPTH) ? DEPTH : int'(it);
        fl.push_back('{int'(ia), lat, cyc});
      end
    end
  endtask

  // Assert reset for one cycle with the current read addresses held, so any
  // stale match would show up immediately.
  task automatic do_reset(input logic [63:0] rf);
    exp_t e;
    @(negedge clk);
    rst_n   = 1'b0;
    rf_data = rf;
    #1;
    fl.delete();
    m_cnt = '0;
    e.st  = 1'b0;
    e.d0  = rf[31:0];
    e.d1  = rf[63:32];
    e.cnt = '0;
    exp_q.push_back(e);
    -> sample_ev;
    @(posedge clk);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      #1;
      if (exp_q.size() == 0) begin
        n_test++;
        n_fail++;
        $display("FAIL queue_empty: got 0 entries want >=1");
      end else begin
        e = exp_q.pop_front();
        n_txn++;
        if (stall) dut_stall_seen++;
        $display("[TB] txn %0d rd_addr=%h stall=%0b rd0=%h rd1=%h", n_txn, rd_addr, stall,
                 rd_data[31:0], rd_data[63:32]);
        chk("stall", {31'd0, stall}, {31'd0, e.st});
        chk("rd_data0", rd_data[31:0], e.d0);
        chk("rd_data1", rd_data[63:32], e.d1);
`ifdef HAZARD_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, e.cnt);
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int s_before;
    rst_n     = 1'b0;
    iss_valid = 1'b0;
    iss_addr  = '0;
    iss_tnew  = '0;
    flush     = 1'b0;
    stg_data  = '0;
    rd_addr   = '0;
    rd_tuse   = '0;
    rf_data   = '0;

    do_reset(r64());

    // Load-use: producer with latency 2, consumer needs it now.
    step(1'b1, 5'd8, 2'd2, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, r96(), r64());
    s_before = dut_stall_seen;
    repeat (3) step(1'b0, 5'd0, 2'd0, 1'b0, 5'd8, 2'd0, 5'd0, 2'd0, r96(), r64());
    chk("loaduse_stall_cycles", 32'(dut_stall_seen - s_before), 32'd2);
    repeat (2) step(1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, r96(), r64());

    // Youngest wins: two producers of r5, stage0 holds 0xA, stage1 holds 0xB.
    step(1'b1, 5'd5, 2'd0, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, r96(), r64());
    step(1'b1, 5'd5, 2'd0, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, r96(), r64());
    step(1'b0, 5'd0, 2'd0, 1'b0, 5'd5, 2'd0, 5'd5, 2'd0,
         {32'h0000_000C, 32'h0000_000B, 32'h0000_000A}, r64());

    // Zero register: never forwards, never stalls.
    step(1'b1, 5'd0, 2'd2, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, r96(), r64());
    step(1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, r96(), r64());

    // Flush while stalled, with a competing issue in the same cycle.
    step(1'b1, 5'd9, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, r96(), r64());
    step(1'b1, 5'd9, 2'd1, 1'b1, 5'd9, 2'd0, 5'd0, 2'd0, r96(), r64());
    step(1'b0, 5'd0, 2'd0, 1'b0, 5'd9, 2'd0, 5'd9, 2'd0, r96(), r64());

    // Reset while stalled: nothing survives.
    step(1'b1, 5'd10, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, r96(), r64());
    step(1'b0, 5'd0, 2'd0, 1'b0, 5'd10, 2'd0, 5'd10, 2'd1, r96(), r64());
    do_reset(r64());
    step(1'b0, 5'd0, 2'd0, 1'b0, 5'd10, 2'd0, 5'd10, 2'd0, r96(), r64());

    // Randomized traffic over a small register set to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset(r64());
      end else begin
        step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 19) == 0),
             5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             r96(), r64());
      end
    end

    @(negedge clk);
    #5;
    n_test++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d entries want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end

endmodule : tb_hazard_fwd_unit

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 SHALL have parameter NUM_RD, default 2, meaning the number of decode-stage read ports.
REQ-002 SHALL have parameter DEPTH, default 3, meaning the number of in-flight stages after decode (E, M, W).
REQ-003 SHALL have parameter DW, default 32, meaning the data width; parameter AW, default 5, meaning the register address width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have ports iss_valid (input, 1), iss_addr (input, AW) and iss_tnew (input, TW): the destination of the decoded instruction and its result latency in cycles.
REQ-007 SHALL have port flush, input, 1 bit: clears all in-flight entries.
REQ-008 SHALL have port stg_data, input, DEPTH*DW: result data per stage; slice k belongs to stage k.
REQ-009 SHALL have ports rd_addr (input, NUM_RD*AW), rd_tuse (input, NUM_RD*TW) and rf_data (input, NUM_RD*DW): one slice per read port.
REQ-010 SHALL have port rd_data, output, NUM_RD*DW: forwarded or register-file operand per port.
REQ-011 SHALL have port stall, output, 1 bit: freezes fetch/decode.

Function
REQ-012 SHALL hold DEPTH entries {valid, addr, tnew}; stage 0 is the youngest.
REQ-013 SHALL, on every clock edge with flush=0, shift entry k-1 into entry k, decrementing tnew and saturating at 0; entry DEPTH-1 retires.
REQ-014 SHALL load stage 0 from the issue port when stall=0, with valid = iss_valid && iss_addr!=0 and tnew = min(iss_tnew, DEPTH).
REQ-015 SHALL load an invalid bubble into stage 0 when stall=1, while older stages still advance.
REQ-016 SHALL, per read port i, match on the youngest valid entry with addr==rd_addr[i] and rd_addr[i]!=0.
REQ-017 SHALL output rd_data[i] = stg_data[k] when the matched entry k has tnew==0; otherwise rd_data[i] = rf_data[i].
REQ-018 SHALL assert stall combinationally when any port's matched entry has tnew > rd_tuse[i].
REQ-019 SHALL never forward or stall for address 0.
REQ-020 SHALL, on flush, clear every valid bit at the next edge; flush overrides a simultaneous stall and issue.

Reset
REQ-021 SHALL, on rst_n low, asynchronously clear all valid bits, tnew and addr; stall=0 and rd_data=rf_data from then until the first issue.
REQ-022 SHALL treat reset asserted mid-stall identically to REQ-021; no entry survives.

Configuration
REQ-023 SHALL, with HAZARD_STALL_CNT_EN defined, add output stall_cnt (32 bit) counting cycles with stall=1, wrapping at 2^32 and reset to 0; without the macro, the port and counter SHALL be absent.

Structure
REQ-024 SHALL place AW, DW, TW = $clog2(DEPTH+1) and the entry typedef {valid, addr, tnew} in package hazard_pkg.
REQ-025 SHALL instantiate sub-module fwd_port_sel once per read port; it performs youngest-match selection and produces the data mux output and a per-port stall request.

Verification (DEPTH=3, NUM_RD=2)
REQ-026 SHALL cover reset: rst_n=0 mid-run -> stall=0 and rd_data==rf_data immediately.
REQ-027 SHALL cover a load-use hazard: issue addr 8 with tnew=2, then read addr 8 with tuse=0 -> stall=1 for exactly 2 cycles, then rd_data=stg_data[2].
REQ-028 SHALL cover youngest-wins: addr 5 at stage0 (tnew 0, data 0xA) and stage1 (tnew 0, data 0xB) -> rd_data=0xA with no stall.
REQ-029 SHALL cover the zero register: issue addr 0 with tnew 2, then read addr 0 -> stall=0 and rd_data=rf_data.
REQ-030 SHALL cover flush during stall: flush=1 while stall=1 -> next cycle stall=0 and all valid bits clear.
REQ-031 SHALL cover the counter with HAZARD_STALL_CNT_EN defined: the REQ-027 sequence -> stall_cnt=2.
